// File: rtl/ternary_register_file_if.sv
// Register-file access bundle: two read ports, one write port, encode-error flag.
// Master drives addresses, strobes and write data; slave returns registered read data.
interface ternary_register_file_if #(
  parameter int WORD_SIZE  = 9,
  parameter int ADDR_TRITS = 2
);
  logic                    rd_en;
  logic [2*ADDR_TRITS-1:0] rd_addr1;
  logic [2*ADDR_TRITS-1:0] rd_addr2;
  logic [2*WORD_SIZE-1:0]  read_data1;
  logic [2*WORD_SIZE-1:0]  read_data2;
  logic                    read_valid;
  logic                    wr_en;
  logic [2*ADDR_TRITS-1:0] wr_addr;
  logic [2*WORD_SIZE-1:0]  wr_data;
  logic                    encode_error;

  modport master (
    output rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
    input  read_data1, read_data2, read_valid, encode_error
  );

  modport slave (
    input  rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
    output read_data1, read_data2, read_valid, encode_error
  );
endinterface

// File: rtl/ternary_register_file.sv
// Balanced-ternary operand register file: 3**ADDR_TRITS words, centre address is hardwired zero.
// Two read ports with 1-cycle registered latency and same-cycle write bypass; illegal trit codes pulse encode_error.
module ternary_register_file #(
  parameter int WORD_SIZE  = 9,
  parameter int ADDR_TRITS = 2
) (
  input logic                     clock,
  input logic                     reset,
  ternary_register_file_if.slave  rf
);

  localparam int NREG  = 3**ADDR_TRITS;
  localparam int IDX_W = $clog2(NREG);
  localparam int DW    = 2*WORD_SIZE;
  localparam int AW    = 2*ADDR_TRITS;

  typedef logic [DW-1:0]    word_t;
  typedef logic [AW-1:0]    addr_t;
  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t ZERO_IDX = idx_t'(NREG/2);

  function automatic logic addr_legal(input addr_t a);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < ADDR_TRITS; i++) begin
      if (a[2*i +: 2] == 2'b10) ok = 1'b0;
    end
    return ok;
  endfunction

  // Most-significant trit first; the signed value is offset so -max lands on index 0.
  function automatic idx_t addr_index(input addr_t a);
    int v;
    v = 0;
    for (int i = ADDR_TRITS-1; i >= 0; i--) begin
      v = v * 3;
      case (a[2*i +: 2])
        2'b01:   v = v + 1;
        2'b11:   v = v - 1;
        default: v = v;
      endcase
    end
    return idx_t'(v + NREG/2);
  endfunction

  function automatic word_t canon_word(input word_t d);
    word_t r;
    r = d;
    for (int i = 0; i < WORD_SIZE; i++) begin
      if (d[2*i +: 2] == 2'b10) r[2*i +: 2] = 2'b00;
    end
    return r;
  endfunction

  function automatic logic word_illegal(input word_t d);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < WORD_SIZE; i++) begin
      if (d[2*i +: 2] == 2'b10) bad = 1'b1;
    end
    return bad;
  endfunction

  word_t regs_q [NREG];
  word_t regs_d [NREG];
  word_t rdata1_q, rdata1_d;
  word_t rdata2_q, rdata2_d;
  logic  rvalid_q, rvalid_d;
  logic  err_q, err_d;

  logic  wr_legal, rd1_legal, rd2_legal;
  idx_t  wr_idx, rd1_idx, rd2_idx;
  word_t wr_word;
  logic  wr_commit;
  logic  byp1, byp2;

  always_comb begin
    wr_legal  = addr_legal(rf.wr_addr);
    rd1_legal = addr_legal(rf.rd_addr1);
    rd2_legal = addr_legal(rf.rd_addr2);
    wr_idx    = addr_index(rf.wr_addr);
    rd1_idx   = addr_index(rf.rd_addr1);
    rd2_idx   = addr_index(rf.rd_addr2);
    wr_word   = canon_word(rf.wr_data);
    wr_commit = rf.wr_en && wr_legal && (wr_idx != ZERO_IDX);

    // A committed write never targets the zero register, so bypass cannot leak into it.
    byp1 = wr_commit && rf.rd_en && rd1_legal && (rd1_idx == wr_idx);
    byp2 = wr_commit && rf.rd_en && rd2_legal && (rd2_idx == wr_idx);

    for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
    if (wr_commit) regs_d[wr_idx] = wr_word;

    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    if (rf.rd_en) begin
      if (!rd1_legal || rd1_idx == ZERO_IDX) rdata1_d = '0;
      else if (byp1)                         rdata1_d = wr_word;
      else                                   rdata1_d = regs_q[rd1_idx];

      if (!rd2_legal || rd2_idx == ZERO_IDX) rdata2_d = '0;
      else if (byp2)                         rdata2_d = wr_word;
      else                                   rdata2_d = regs_q[rd2_idx];
    end
    rvalid_d = rf.rd_en;

    err_d = (rf.rd_en && (!rd1_legal || !rd2_legal)) ||
            (rf.wr_en && (!wr_legal || word_illegal(rf.wr_data)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign rf.read_data1   = rdata1_q;
  assign rf.read_data2   = rdata2_q;
  assign rf.read_valid   = rvalid_q;
  assign rf.encode_error = err_q;

endmodule

// File: tb/tb_ternary_register_file.sv
// Directed bench for ternary_register_file: hand-computed vectors, one task per scenario.
module tb_ternary_register_file;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  ternary_register_file_if tif ();

  ternary_register_file dut (
    .clock (clock),
    .reset (reset),
    .rf    (tif)
  );

  always #5 clock = ~clock;

  localparam logic [17:0] W118  = {2'b00,2'b00,2'b00,2'b00,2'b01,2'b01,2'b01,2'b00,2'b01};
  localparam logic [17:0] WM107 = {2'b00,2'b00,2'b00,2'b00,2'b11,2'b11,2'b00,2'b00,2'b01};
  localparam logic [17:0] WNEG  = {9{2'b11}};
  localparam logic [17:0] WPOS  = {9{2'b01}};
  localparam logic [17:0] WALT  = {2'b01,2'b11,2'b01,2'b11,2'b00,2'b00,2'b01,2'b01,2'b11};
  localparam logic [17:0] WBADIN = {2'b01,2'b10,2'b11,2'b00,2'b01,2'b01,2'b10,2'b11,2'b10};
  localparam logic [17:0] WBADCN = {2'b01,2'b00,2'b11,2'b00,2'b01,2'b01,2'b00,2'b11,2'b00};

  // addr_tab[i] is the 2-trit code whose physical index is i
  logic [3:0]  addr_tab [9] = '{4'b1111, 4'b1100, 4'b1101, 4'b0011, 4'b0000,
                                4'b0001, 4'b0111, 4'b0100, 4'b0101};
  logic [17:0] exp_mem  [9];

  task automatic idle();
    tif.rd_en = 1'b0; tif.rd_addr1 = '0; tif.rd_addr2 = '0;
    tif.wr_en = 1'b0; tif.wr_addr  = '0; tif.wr_data  = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [17:0] d);
    tif.wr_en = 1'b1; tif.wr_addr = a; tif.wr_data = d;
    tick();
    idle();
  endtask

  task automatic rd(input logic [3:0] a1, input logic [3:0] a2);
    tif.rd_en = 1'b1; tif.rd_addr1 = a1; tif.rd_addr2 = a2;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    tif.rd_en = 1'b1; tif.wr_en = 1'b1; tif.wr_addr = 4'b0101; tif.wr_data = WPOS;
    tick();
    idle();
    total++;
    if ({tif.read_data1, tif.read_data2, tif.read_valid, tif.encode_error} !== 38'd0) begin
      bad++; $display("FAIL reset_outputs got=%h/%h v=%b e=%b exp=0", tif.read_data1, tif.read_data2, tif.read_valid, tif.encode_error);
    end
    reset = 1'b0;
    rd(4'b0101, 4'b1111);
    total++;
    if (tif.read_data1 !== 18'd0 || tif.read_data2 !== 18'd0) begin
      bad++; $display("FAIL reset_regs got=%h/%h exp=0/0", tif.read_data1, tif.read_data2);
    end
    total++;
    if ({tif.read_valid, tif.encode_error} !== 2'b10) begin
      bad++; $display("FAIL reset_first_read v/e got=%b%b exp=10", tif.read_valid, tif.encode_error);
    end
    for (int i = 0; i < 9; i++) exp_mem[i] = '0;
  endtask

  task automatic test_write_read();
    wr(4'b0001, W118); exp_mem[5] = W118;
    total++;
    if (tif.encode_error !== 1'b0) begin
      bad++; $display("FAIL write_err got=%b exp=0", tif.encode_error);
    end
    rd(4'b0001, 4'b0011);
    total++;
    if (tif.read_data1 !== W118) begin
      bad++; $display("FAIL read118 got=%h exp=%h", tif.read_data1, W118);
    end
    total++;
    if (tif.read_data2 !== 18'd0 || tif.read_valid !== 1'b1) begin
      bad++; $display("FAIL read_m1 got=%h v=%b exp=0 v=1", tif.read_data2, tif.read_valid);
    end
  endtask

  task automatic test_hold();
    tif.rd_addr1 = 4'b1111; tif.rd_addr2 = 4'b0101;
    tick();
    total++;
    if (tif.read_data1 !== W118 || tif.read_data2 !== 18'd0 || tif.read_valid !== 1'b0) begin
      bad++; $display("FAIL hold got=%h/%h v=%b exp=%h/0 v=0", tif.read_data1, tif.read_data2, tif.read_valid, W118);
    end
  endtask

  task automatic test_bypass();
    tif.wr_en = 1'b1; tif.wr_addr = 4'b0111; tif.wr_data = WM107;
    tif.rd_en = 1'b1; tif.rd_addr1 = 4'b0111; tif.rd_addr2 = 4'b0111;
    tick();
    idle();
    exp_mem[6] = WM107;
    total++;
    if (tif.read_data1 !== WM107 || tif.read_data2 !== WM107) begin
      bad++; $display("FAIL bypass_both got=%h/%h exp=%h", tif.read_data1, tif.read_data2, WM107);
    end
    // port 1 bypasses the new value, port 2 sees stored contents
    tif.wr_en = 1'b1; tif.wr_addr = 4'b0001; tif.wr_data = WALT;
    tif.rd_en = 1'b1; tif.rd_addr1 = 4'b0001; tif.rd_addr2 = 4'b0111;
    tick();
    idle();
    exp_mem[5] = WALT;
    total++;
    if (tif.read_data1 !== WALT || tif.read_data2 !== WM107) begin
      bad++; $display("FAIL bypass_port1 got=%h/%h exp=%h/%h", tif.read_data1, tif.read_data2, WALT, WM107);
    end
  endtask

  task automatic test_no_alias();
    wr(4'b1111, WNEG); exp_mem[0] = WNEG;
    wr(4'b0101, WPOS); exp_mem[8] = WPOS;
    rd(4'b1111, 4'b0101);
    total++;
    if (tif.read_data1 !== WNEG || tif.read_data2 !== WPOS) begin
      bad++; $display("FAIL no_alias got=%h/%h exp=%h/%h", tif.read_data1, tif.read_data2, WNEG, WPOS);
    end
  endtask

  task automatic test_zero_reg();
    wr(4'b0000, WPOS);
    rd(4'b0000, 4'b0000);
    total++;
    if (tif.read_data1 !== 18'd0 || tif.read_data2 !== 18'd0 || tif.encode_error !== 1'b0) begin
      bad++; $display("FAIL zero_reg got=%h/%h e=%b exp=0/0 e=0", tif.read_data1, tif.read_data2, tif.encode_error);
    end
    tif.wr_en = 1'b1; tif.wr_addr = 4'b0000; tif.wr_data = WNEG;
    tif.rd_en = 1'b1; tif.rd_addr1 = 4'b0000; tif.rd_addr2 = 4'b0101;
    tick();
    idle();
    total++;
    if (tif.read_data1 !== 18'd0 || tif.read_data2 !== WPOS) begin
      bad++; $display("FAIL zero_nobypass got=%h/%h exp=0/%h", tif.read_data1, tif.read_data2, WPOS);
    end
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 9; i++) begin
      rd(addr_tab[i], addr_tab[8-i]);
      total++;
      if (tif.read_data1 !== exp_mem[i] || tif.read_data2 !== exp_mem[8-i]) begin
        bad++; $display("FAIL %s idx%0d got=%h/%h exp=%h/%h", tag, i, tif.read_data1, tif.read_data2, exp_mem[i], exp_mem[8-i]);
      end
    end
  endtask

  task automatic test_illegal_addr();
    wr(4'b1001, WNEG);
    total++;
    if (tif.encode_error !== 1'b1) begin
      bad++; $display("FAIL ill_wr_err got=%b exp=1", tif.encode_error);
    end
    tick();
    total++;
    if (tif.encode_error !== 1'b0) begin
      bad++; $display("FAIL ill_wr_pulse got=%b exp=0", tif.encode_error);
    end
    read_all("ill_wr_regs");
    rd(4'b1000, 4'b0101);
    total++;
    if (tif.read_data1 !== 18'd0 || tif.read_data2 !== WPOS || {tif.read_valid, tif.encode_error} !== 2'b11) begin
      bad++; $display("FAIL ill_rd got=%h/%h v=%b e=%b exp=0/%h v=1 e=1", tif.read_data1, tif.read_data2, tif.read_valid, tif.encode_error, WPOS);
    end
    // disabled ports are not checked
    tif.rd_addr1 = 4'b1010; tif.wr_addr = 4'b1010; tif.wr_data = WBADIN;
    tick();
    idle();
    total++;
    if (tif.encode_error !== 1'b0) begin
      bad++; $display("FAIL ill_disabled got=%b exp=0", tif.encode_error);
    end
  endtask

  task automatic test_illegal_data();
    wr(4'b0100, WBADIN); exp_mem[7] = WBADCN;
    total++;
    if (tif.encode_error !== 1'b1) begin
      bad++; $display("FAIL ill_data_err got=%b exp=1", tif.encode_error);
    end
    // back-to-back error cycles keep the flag high
    wr(4'b1010, WPOS);
    total++;
    if (tif.encode_error !== 1'b1) begin
      bad++; $display("FAIL ill_b2b got=%b exp=1", tif.encode_error);
    end
    rd(4'b0100, 4'b0100);
    total++;
    if (tif.read_data1 !== WBADCN || tif.read_data2 !== WBADCN || tif.encode_error !== 1'b0) begin
      bad++; $display("FAIL ill_data_rd got=%h/%h e=%b exp=%h e=0", tif.read_data1, tif.read_data2, tif.encode_error, WBADCN);
    end
  endtask

  task automatic test_reset_priority();
    reset = 1'b1;
    tif.wr_en = 1'b1; tif.wr_addr = 4'b1101; tif.wr_data = WBADIN;
    tif.rd_en = 1'b1; tif.rd_addr1 = 4'b0101; tif.rd_addr2 = 4'b1010;
    tick();
    idle();
    reset = 1'b0;
    total++;
    if ({tif.read_data1, tif.read_data2, tif.read_valid, tif.encode_error} !== 38'd0) begin
      bad++; $display("FAIL rst_prio got=%h/%h v=%b e=%b exp=0", tif.read_data1, tif.read_data2, tif.read_valid, tif.encode_error);
    end
    for (int i = 0; i < 9; i++) exp_mem[i] = '0;
    read_all("rst_regs");
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_hold();
    test_bypass();
    test_no_alias();
    test_zero_reg();
    test_illegal_addr();
    test_illegal_data();
    test_reset_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ternary_register_file.md
Name: ternary_register_file

Overview:
- Operand register file for the 9-trit ternary datapath.
- Supplies input1/input2 to ternary_alu through two registered read ports, and accepts alu_out as write-back data.
- Registers are addressed by 2-trit balanced-ternary addresses, giving 9 registers; address 0 is a hardwired zero register.
- Trit encoding throughout: 2'b11 = -1, 2'b00 = 0, 2'b01 = +1; 2'b10 is illegal.

Parameters:
- WORD_SIZE, 9, trits per data word; data buses are 2*WORD_SIZE bits.
- ADDR_TRITS, 2, trits per register address; register count = 3**ADDR_TRITS.

Ports:
- clock  input  1  single system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- rd_en  input  1  read strobe for both read ports.
- rd_addr1  input  2*ADDR_TRITS  read port 1 address (ternary).
- rd_addr2  input  2*ADDR_TRITS  read port 2 address (ternary).
- read_data1  output  2*WORD_SIZE  registered read data, port 1 (to ALU input1).
- read_data2  output  2*WORD_SIZE  registered read data, port 2 (to ALU input2).
- read_valid  output  1  high for the cycle after an accepted rd_en.
- wr_en  input  1  write strobe.
- wr_addr  input  2*ADDR_TRITS  write address (ternary).
- wr_data  input  2*WORD_SIZE  write-back data (from ALU alu_out).
- encode_error  output  1  registered one-cycle pulse on any illegal trit code seen this cycle.

Behaviour:
- Address decode:
  - value = a1*3 + a0 (balanced ternary, MS trit first), range -4..+4.
  - Physical index = value + 4 (0..8).
  - Examples: {11,11} = -4 maps to index 0; {01,01} = +4 maps to index 8.
  - Value 0 ({00,00}) is the zero register: reads return all 2'b00, writes are ignored.
- Reset (synchronous, priority over all else):
  - All 9 registers are cleared to all-zero trits.
  - read_data1, read_data2 = 0; read_valid = 0; encode_error = 0.
  - wr_en or rd_en asserted in a reset cycle has no effect.
- Write:
  - On posedge with wr_en=1, a legal wr_addr and a nonzero register, wr_data is stored.
  - Any wr_data trit equal to 2'b10 is stored as 2'b00 and flags an encode error.
- Read:
  - 1-cycle latency. On posedge with rd_en=1, read_data1/2 load the contents at rd_addr1/2 and read_valid=1 next cycle.
  - With rd_en=0, read_data1/2 hold their last value and read_valid=0.
- Same-cycle read/write (bypass):
  - If wr_en and rd_en are both asserted and rd_addrN == wr_addr (legal, nonzero), read_dataN gets the canonicalised wr_data, not the old contents.
  - Each port is bypassed independently; both ports may bypass at once.
  - A read of the zero register is never bypassed.
- Illegal address (any trit 2'b10 in rd_addrN or wr_addr):
  - The write is dropped.
  - That read port returns all-zero (read_valid still asserts).
  - encode_error = 1 for exactly the next cycle.
  - Only addresses on enabled ports are checked: rd_addr1/2 when rd_en=1, wr_addr when wr_en=1.
- encode_error is the OR of all error sources in a cycle and pulses once per offending cycle; back-to-back errors keep it high.
- No wrap-around: all 9 codes map to distinct registers. Register contents persist indefinitely without reset.

Test Plan:
- Reset, then rd_en with rd_addr1={01,01}, rd_addr2={11,11} -> next cycle both read_data = 0, read_valid=1, encode_error=0.
- Write 118 = [0,0,0,0,1,1,1,0,1] to {00,01}, then read it on port 1 and read {00,11} (-1) on port 2 -> read_data1 = 118 encoding, read_data2 = 0.
- Same cycle: write -107 = [0,0,0,0,-1,-1,0,0,1] to {01,11} with rd_addr1 = rd_addr2 = {01,11} -> both ports show -107 next cycle (bypass). Then write all -1 to {11,11} and all +1 to {01,01}, read both -> values stay distinct (no aliasing of index 0 and index 8).
- Write all +1 to {00,00}, then read {00,00} -> 0; no encode_error.
- Write with wr_addr={10,01} -> no register changes (check by reading all 9 registers), encode_error pulses exactly 1 cycle. Write wr_data containing a 2'b10 trit -> that trit reads back 2'b00 and encode_error pulses.
- Fill registers, then assert reset together with wr_en and rd_en -> next cycle all outputs 0; subsequent reads of all 9 addresses return 0.
